// File: rtl/x_ram16_fifo_ctrl_if.sv
// ---------------------------------------------------------------------------
// x_ram16_fifo_ctrl_if
// Bundles the push/pop handshakes, the RAM-bank signals and the fill count
// of the x_ram16_fifo_ctrl FIFO controller.
//   slave  : the controller itself
//   master : the environment (producer, consumer and the X_RAM16 bank)
// Signals:
//   in_valid/in_ready/in_data      push handshake
//   out_valid/out_ready/out_data   pop handshake (out_data is the output reg)
//   ram_adr/ram_we/ram_di          registered controls shared by every cell
//   ram_do                         async-read data from the cells
//   count                          words held, 0..17
// ---------------------------------------------------------------------------
interface x_ram16_fifo_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       ram_adr;
  logic             ram_we;
  logic [WIDTH-1:0] ram_di;
  logic [WIDTH-1:0] ram_do;
  logic [4:0]       count;

  modport slave (
    input  in_valid, in_data, out_ready, ram_do,
    output in_ready, out_valid, out_data, ram_adr, ram_we, ram_di, count
  );

  modport master (
    output in_valid, in_data, out_ready, ram_do,
    input  in_ready, out_valid, out_data, ram_adr, ram_we, ram_di, count
  );
endinterface

// File: rtl/x_ram16_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// x_ram16_fifo_ctrl
// FIFO controller in front of a WIDTH-bit bank of 16x1 single-port,
// async-read distributed RAM cells that share ADR/WE. Push/pop valid/ready
// traffic becomes one registered RAM operation per cycle (IDLE, WRITE or
// READ). Read data lands in an output register, so capacity is 16 RAM
// words plus the output word = 17.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (drops contents, RAM untouched)
//   bus    slave side of x_ram16_fifo_ctrl_if (handshakes, RAM, count)
// ---------------------------------------------------------------------------
module x_ram16_fifo_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  x_ram16_fifo_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } op_e;

  // Registered state
  op_e              op_r;
  logic [3:0]       wptr_r;
  logic [3:0]       rptr_r;
  logic [4:0]       ram_cnt_r;      // includes a write still in flight
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [3:0]       ram_adr_r;
  logic             ram_we_r;
  logic [WIDTH-1:0] ram_di_r;
  logic [4:0]       count_r;
  logic             run_r;          // holds in_ready low until the first edge after reset

  // Decisions for the current cycle
  logic             out_free_s;
  logic             read_done_s;
  logic             issue_read_s;
  logic             bypass_s;
  logic             wr_ok_s;
  logic             in_ready_s;
  logic             push_s;
  logic             bypass_push_s;
  logic             write_push_s;

  // Next-state values
  op_e              op_nxt_s;
  logic [3:0]       wptr_nxt_s;
  logic [3:0]       rptr_nxt_s;
  logic [4:0]       ram_cnt_nxt_s;
  logic             out_valid_nxt_s;
  logic [WIDTH-1:0] out_data_nxt_s;
  logic [3:0]       ram_adr_nxt_s;
  logic             ram_we_nxt_s;
  logic [WIDTH-1:0] ram_di_nxt_s;
  logic [4:0]       count_nxt_s;

  // Per-cycle arbitration: READ beats a RAM write, bypass only when nothing is in RAM
  always_comb begin
    out_free_s    = !out_valid_r || bus.out_ready;
    // A READ issued last edge completes at this edge; the next READ waits one slot.
    read_done_s   = (op_r == OP_READ);
    issue_read_s  = run_r && (ram_cnt_r != 5'd0) && out_free_s && !read_done_s;
    bypass_s      = run_r && (ram_cnt_r == 5'd0) && out_free_s && !read_done_s;
    wr_ok_s       = run_r && !bypass_s && (ram_cnt_r < 5'd16) && !issue_read_s;
    in_ready_s    = bypass_s || wr_ok_s;
    push_s        = bus.in_valid && in_ready_s;
    bypass_push_s = push_s && bypass_s;
    write_push_s  = push_s && !bypass_s;
  end

  // Next RAM operation and its registered address/data
  always_comb begin
    op_nxt_s      = OP_IDLE;
    ram_adr_nxt_s = ram_adr_r;
    ram_we_nxt_s  = 1'b0;
    ram_di_nxt_s  = ram_di_r;
    if (issue_read_s) begin
      op_nxt_s      = OP_READ;
      ram_adr_nxt_s = rptr_r;
    end else if (write_push_s) begin
      op_nxt_s      = OP_WRITE;
      ram_adr_nxt_s = wptr_r;
      ram_we_nxt_s  = 1'b1;
      ram_di_nxt_s  = bus.in_data;
    end else begin
      op_nxt_s      = OP_IDLE;
    end
  end

  // Pointer and RAM occupancy updates
  always_comb begin
    wptr_nxt_s = write_push_s ? (wptr_r + 4'd1) : wptr_r;
    // rptr advances when the read completes, not when it is issued
    rptr_nxt_s = read_done_s ? (rptr_r + 4'd1) : rptr_r;
    if (write_push_s && !read_done_s) begin
      ram_cnt_nxt_s = ram_cnt_r + 5'd1;
    end else if (read_done_s && !write_push_s) begin
      ram_cnt_nxt_s = ram_cnt_r - 5'd1;
    end else begin
      ram_cnt_nxt_s = ram_cnt_r;
    end
  end

  // Output register: RAM load, bypass load, plain pop or hold
  always_comb begin
    out_valid_nxt_s = out_valid_r;
    out_data_nxt_s  = out_data_r;
    if (read_done_s) begin
      // The slot was freed when the READ was issued, so the load is unconditional.
      out_valid_nxt_s = 1'b1;
      out_data_nxt_s  = bus.ram_do;
    end else if (bypass_push_s) begin
      out_valid_nxt_s = 1'b1;
      out_data_nxt_s  = bus.in_data;
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
    count_nxt_s = ram_cnt_nxt_s + {4'd0, out_valid_nxt_s};
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r        <= OP_IDLE;
      wptr_r      <= 4'd0;
      rptr_r      <= 4'd0;
      ram_cnt_r   <= 5'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      ram_adr_r   <= 4'd0;
      ram_we_r    <= 1'b0;
      ram_di_r    <= '0;
      count_r     <= 5'd0;
      run_r       <= 1'b0;
    end else begin
      op_r        <= op_nxt_s;
      wptr_r      <= wptr_nxt_s;
      rptr_r      <= rptr_nxt_s;
      ram_cnt_r   <= ram_cnt_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_data_r  <= out_data_nxt_s;
      ram_adr_r   <= ram_adr_nxt_s;
      ram_we_r    <= ram_we_nxt_s;
      ram_di_r    <= ram_di_nxt_s;
      count_r     <= count_nxt_s;
      run_r       <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.ram_adr   = ram_adr_r;
  assign bus.ram_we    = ram_we_r;
  assign bus.ram_di    = ram_di_r;
  assign bus.count     = count_r;

endmodule
